// File: rtl/plusarg_num_parse.sv
// Serial plusarg-style number parser: scans a NUL-padded ASCII string one character per cycle.
// Optional macro PLUSARG_NUM_PARSE_HEX_EN adds "0x"/"0X" hexadecimal support.
module plusarg_num_parse #(
    parameter int LENGTH = 200,
    parameter int WIDTH  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [0:LENGTH*8-1] val,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    value,
    output logic                error,
    output logic                ovf
);
    localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t               state_q, state_d;
    logic [0:LENGTH*8-1]  sr_q, sr_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 seen_q, seen_d;
    logic                 serr_q, serr_d;
    logic                 sovf_q, sovf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     value_q, value_d;
    logic                 error_q, error_d;
    logic                 ovf_q, ovf_d;
`ifdef PLUSARG_NUM_PARSE_HEX_EN
    logic                 hex_q, hex_d;
    logic                 zero1_q, zero1_d;
`endif

    logic [7:0]           ch;
    logic                 is_dig;
    logic [3:0]           dig_val;
    logic [WIDTH+3:0]     acc_ext;
    logic [WIDTH+3:0]     wide;
    logic                 fin_err;

    assign ch = sr_q[0:7];

    // Character classification; hex letters only count once the prefix has been seen.
    always_comb begin
        is_dig  = 1'b0;
        dig_val = 4'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            is_dig  = 1'b1;
            dig_val = 4'(ch - 8'h30);
        end
`ifdef PLUSARG_NUM_PARSE_HEX_EN
        else if (hex_q && ch >= 8'h61 && ch <= 8'h66) begin
            is_dig  = 1'b1;
            dig_val = 4'(ch - 8'h57);
        end else if (hex_q && ch >= 8'h41 && ch <= 8'h46) begin
            is_dig  = 1'b1;
            dig_val = 4'(ch - 8'h37);
        end
`endif
    end

    // Four guard bits above the accumulator catch any overflow from one multiply-add step.
    always_comb begin
        acc_ext = {4'b0000, acc_q};
`ifdef PLUSARG_NUM_PARSE_HEX_EN
        if (hex_q)
            wide = (acc_ext << 4) + {{WIDTH{1'b0}}, dig_val};
        else
`endif
        wide = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, dig_val};
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        seen_d  = seen_q;
        serr_d  = serr_q;
        sovf_d  = sovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        value_d = value_q;
        error_d = error_q;
        ovf_d   = ovf_q;
        fin_err = 1'b0;
`ifdef PLUSARG_NUM_PARSE_HEX_EN
        hex_d   = hex_q;
        zero1_d = zero1_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    sr_d    = val;
                    idx_d   = '0;
                    acc_d   = '0;
                    seen_d  = 1'b0;
                    serr_d  = 1'b0;
                    sovf_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef PLUSARG_NUM_PARSE_HEX_EN
                    hex_d   = 1'b0;
                    zero1_d = 1'b0;
`endif
                end
            end
            SCAN: begin
                sr_d  = sr_q << 8;
                idx_d = idx_q + 1'b1;
                if (ch == 8'h00) begin
                    if (seen_q)
                        serr_d = 1'b1;
                end else begin
                    seen_d = 1'b1;
`ifdef PLUSARG_NUM_PARSE_HEX_EN
                    // zero1 marks "exactly one non-NUL seen and it was '0'".
                    zero1_d = !seen_q && (ch == 8'h30);
                    if (zero1_q && (ch == 8'h78 || ch == 8'h58))
                        hex_d = 1'b1;
                    else
`endif
                    if (!is_dig)
                        serr_d = 1'b1;
                    else if (sovf_q)
                        acc_d = '1;
                    else if (|wide[WIDTH+3:WIDTH]) begin
                        sovf_d = 1'b1;
                        acc_d  = '1;
                    end else
                        acc_d = wide[WIDTH-1:0];
                end
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    fin_err = serr_d || !seen_d;
                    error_d = fin_err;
                    value_d = fin_err ? '0 : acc_d;
                    ovf_d   = !fin_err && sovf_d;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            seen_q  <= 1'b0;
            serr_q  <= 1'b0;
            sovf_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            value_q <= '0;
            error_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef PLUSARG_NUM_PARSE_HEX_EN
            hex_q   <= 1'b0;
            zero1_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            seen_q  <= seen_d;
            serr_q  <= serr_d;
            sovf_q  <= sovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            value_q <= value_d;
            error_q <= error_d;
            ovf_q   <= ovf_d;
`ifdef PLUSARG_NUM_PARSE_HEX_EN
            hex_q   <= hex_d;
            zero1_q <= zero1_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign value = value_q;
    assign error = error_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_plusarg_num_parse.sv
// Directed self-checking bench for plusarg_num_parse with LENGTH=8, WIDTH=16.
module tb_plusarg_num_parse;
    localparam int LENGTH = 8;
    localparam int WIDTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [0:LENGTH*8-1] val;
    logic              start;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  value;
    logic              error;
    logic              ovf;

    int n_cmp = 0;
    int n_bad = 0;

    plusarg_num_parse #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .val   (val),
        .start (start),
        .busy  (busy),
        .done  (done),
        .value (value),
        .error (error),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Right-aligned string, leading NUL padding.
    function automatic logic [0:63] mk(input string s);
        logic [0:63] r;
        r = '0;
        for (int i = 0; i < s.len(); i++)
            r[(8 - s.len() + i)*8 +: 8] = s[i];
        return r;
    endfunction

    // Left-aligned string, trailing NUL padding.
    function automatic logic [0:63] mkl(input string s);
        logic [0:63] r;
        r = '0;
        for (int i = 0; i < s.len(); i++)
            r[i*8 +: 8] = s[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_parse(input string tag, input logic [0:63] v,
                             input logic [15:0] ev, input logic ee, input logic eo,
                             input int intf_cyc, input logic [0:63] iv);
        int   cnt;
        logic all_busy;
        @(negedge clk);
        val   = v;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cnt      = 1;
        all_busy = busy;
        while (!done && cnt < 20) begin
            if (cnt == intf_cyc) begin
                val   = iv;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cnt++;
            all_busy &= busy;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(cnt), 32'd9);
        chk({tag, " busy"}, {31'd0, all_busy}, 32'd1);
        chk({tag, " value"}, {16'd0, value}, {16'd0, ev});
        chk({tag, " error"}, {31'd0, error}, {31'd0, ee});
        chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        $display("txn %s: value=%0d error=%0b ovf=%0b cycles=%0d", tag, value, error, ovf, cnt);
        @(negedge clk);
        chk({tag, " done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic saw_done;
        reset = 1'b1;
        start = 1'b0;
        val   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst value", {16'd0, value}, 32'd0);
        chk("rst error", {31'd0, error}, 32'd0);
        chk("rst ovf", {31'd0, ovf}, 32'd0);

        run_parse("dec1234", mk("1234"), 16'd1234, 1'b0, 1'b0, 0, '0);
        run_parse("max65535", mk("65535"), 16'hFFFF, 1'b0, 1'b0, 0, '0);
        run_parse("ovf70000", mk("70000"), 16'hFFFF, 1'b0, 1'b1, 0, '0);
        run_parse("ovf8x9", mk("99999999"), 16'hFFFF, 1'b0, 1'b1, 0, '0);
        run_parse("bad12a4", mk("12a4"), 16'd0, 1'b1, 1'b0, 0, '0);
        run_parse("allnul", 64'd0, 16'd0, 1'b1, 1'b0, 0, '0);
        run_parse("ovf_then_err", mk("99999a"), 16'd0, 1'b1, 1'b0, 0, '0);
        run_parse("trail_nul", mkl("12"), 16'd0, 1'b1, 1'b0, 0, '0);
`ifdef PLUSARG_NUM_PARSE_HEX_EN
        run_parse("hex0x1F", mk("0x1F"), 16'd31, 1'b0, 1'b0, 0, '0);
        run_parse("hex0Xff", mk("0Xff"), 16'd255, 1'b0, 1'b0, 0, '0);
`else
        run_parse("hex0x1F", mk("0x1F"), 16'd0, 1'b1, 1'b0, 0, '0);
        run_parse("hex0Xff", mk("0Xff"), 16'd0, 1'b1, 1'b0, 0, '0);
`endif
        run_parse("lead0", mk("00000042"), 16'd42, 1'b0, 1'b0, 0, '0);

        // Outputs hold between completions even as val changes.
        val = mk("777");
        repeat (5) @(negedge clk);
        chk("hold value", {16'd0, value}, 32'd42);

        // Restart attempt mid-scan with new val must be ignored.
        run_parse("restart_ign", mk("1234"), 16'd1234, 1'b0, 1'b0, 4, mk("9"));

        // Reset in SCAN cycle 3 aborts with no done.
        @(negedge clk);
        val   = mk("1234");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort value", {16'd0, value}, 32'd0);
        chk("abort error", {31'd0, error}, 32'd0);
        chk("abort ovf", {31'd0, ovf}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            saw_done |= done;
        end
        chk("abort no_done", {31'd0, saw_done}, 32'd0);
        $display("txn abort: reset mid-scan, done seen=%0b", saw_done);
        run_parse("after_rst42", mk("42"), 16'd42, 1'b0, 1'b0, 0, '0);

        // Start coincident with reset is ignored.
        @(negedge clk);
        val   = mk("5");
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst_start busy2", {31'd0, busy}, 32'd0);
        $display("txn rst_start: busy=%0b", busy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
